// File: rtl/btn_rate_ctrl.sv
// Debounced push-button that steps a blink rate index on each accepted press
// and publishes the matching half-period to a downstream blinker.
module btn_rate_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1,
   parameter logic [31:0] RATE0           = 32'd10000000,
   parameter logic [31:0] RATE1           = 32'd5000000,
   parameter logic [31:0] RATE2           = 32'd2500000,
   parameter logic [31:0] RATE3           = 32'd1250000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_in,
   output logic        btn_level,
   output logic        press,
   output logic [1:0]  rate_idx,
   output logic [31:0] half_period,
   output logic        period_valid
);

   typedef enum logic [1:0] {
      RELEASED,
      CONFIRM_PRESS,
      PRESSED,
      CONFIRM_RELEASE
   } state_t;

   localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);
   localparam logic        IDLE_LVL = logic'(BTN_ACTIVE_LOW);

   state_t      state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic        sync1_q, sync2_q;
   logic        level_q, level_d;
   logic        press_q, press_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] hp_q, hp_d;
   logic        pv_q, pv_d;
   logic        s_pressed;
   logic [1:0]  idx_inc;

   function automatic logic [31:0] rate_of(input logic [1:0] idx);
      logic [31:0] r;
      case (idx)
         2'd0:    r = RATE0;
         2'd1:    r = RATE1;
         2'd2:    r = RATE2;
         default: r = RATE3;
      endcase
      return r;
   endfunction

   assign s_pressed = sync2_q ^ logic'(BTN_ACTIVE_LOW);
   assign idx_inc   = idx_q + 2'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      idx_d   = idx_q;
      hp_d    = hp_q;
      pv_d    = 1'b0;
      case (state_q)
         RELEASED: begin
            if (s_pressed) begin
               state_d = CONFIRM_PRESS;
               cnt_d   = 24'd1;
            end
         end
         CONFIRM_PRESS: begin
            if (!s_pressed) begin
               state_d = RELEASED;
               cnt_d   = 24'd0;
            end else if (cnt_q == CNT_LAST) begin
               // Rate advance and its half-period are published together.
               state_d = PRESSED;
               cnt_d   = 24'd0;
               level_d = 1'b1;
               press_d = 1'b1;
               idx_d   = idx_inc;
               hp_d    = rate_of(idx_inc);
               pv_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end
         PRESSED: begin
            if (!s_pressed) begin
               state_d = CONFIRM_RELEASE;
               cnt_d   = 24'd1;
            end
         end
         CONFIRM_RELEASE: begin
            if (s_pressed) begin
               state_d = PRESSED;
               cnt_d   = 24'd0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = RELEASED;
               cnt_d   = 24'd0;
               level_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = 24'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= IDLE_LVL;
         sync2_q <= IDLE_LVL;
         state_q <= RELEASED;
         cnt_q   <= 24'd0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         idx_q   <= 2'd0;
         hp_q    <= RATE0;
         pv_q    <= 1'b0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         idx_q   <= idx_d;
         hp_q    <= hp_d;
         pv_q    <= pv_d;
      end
   end

   assign btn_level    = level_q;
   assign press        = press_q;
   assign rate_idx     = idx_q;
   assign half_period  = hp_q;
   assign period_valid = pv_q;

endmodule

// File: tb/tb_btn_rate_ctrl.sv
// Scoreboard bench for btn_rate_ctrl: expected press events are queued when
// the button is driven and matched against pulses captured by a monitor.
module tb_btn_rate_ctrl;

   localparam int DB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_in;
   logic        btn_level;
   logic        press;
   logic [1:0]  rate_idx;
   logic [31:0] half_period;
   logic        period_valid;

   always #5 clk = ~clk;

   btn_rate_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .BTN_ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .press       (press),
      .rate_idx    (rate_idx),
      .half_period (half_period),
      .period_valid(period_valid)
   );

   typedef struct {
      int          cyc;
      logic [1:0]  idx;
      logic [31:0] hp;
   } exp_t;

   typedef struct {
      int          cyc;
      logic [1:0]  idx;
      logic [31:0] hp;
      logic        pv;
      logic        lvl;
   } obs_t;

   logic [31:0] rate_tab [4] = '{32'd10000000, 32'd5000000,
                                 32'd2500000, 32'd1250000};

   exp_t       exp_q[$];
   obs_t       obs_q[$];
   int         cyc = 0;
   int         fall_cyc = -1;
   int         dbl_press = 0;
   int         dbl_pv = 0;
   logic       prev_press = 1'b0;
   logic       prev_pv = 1'b0;
   logic       prev_lvl = 1'b0;
   logic [1:0] exp_idx;
   int         n_chk = 0;
   int         n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (press === 1'b1)
         obs_q.push_back(obs_t'{cyc, rate_idx, half_period,
                                period_valid, btn_level});
      if (press === 1'b1 && prev_press === 1'b1) dbl_press++;
      if (period_valid === 1'b1 && prev_pv === 1'b1) dbl_pv++;
      if (btn_level === 1'b0 && prev_lvl === 1'b1) fall_cyc = cyc;
      prev_press = press;
      prev_pv    = period_valid;
      prev_lvl   = btn_level;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_press();
      exp_idx = exp_idx + 2'd1;
      exp_q.push_back(exp_t'{cyc + DB + 2, exp_idx, rate_tab[exp_idx]});
      btn_in = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      exp_idx = 2'd0;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      btn_in = 1'b1;
      do_reset();
      n_chk++;
      if (btn_level !== 1'b0) $display("FAIL reset_level got %b want 0", btn_level);
      else n_pass++;
      n_chk++;
      if (press !== 1'b0) $display("FAIL reset_press got %b want 0", press);
      else n_pass++;
      n_chk++;
      if (rate_idx !== 2'd0) $display("FAIL reset_idx got %0d want 0", rate_idx);
      else n_pass++;
      n_chk++;
      if (half_period !== 32'd10000000)
         $display("FAIL reset_hp got %0d want 10000000", half_period);
      else n_pass++;
      n_chk++;
      if (period_valid !== 1'b0) $display("FAIL reset_pv got %b want 0", period_valid);
      else n_pass++;
   endtask

   task automatic test_press();
      exp_t e;
      obs_t o;
      drive_press();
      tick(10);
      n_chk++;
      if (obs_q.size() != 1) $display("FAIL press_count got %0d want 1", obs_q.size());
      else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_chk++;
         if (o.cyc !== e.cyc) $display("FAIL press_cycle got %0d want %0d", o.cyc, e.cyc);
         else n_pass++;
         n_chk++;
         if (o.idx !== e.idx) $display("FAIL press_idx got %0d want %0d", o.idx, e.idx);
         else n_pass++;
         n_chk++;
         if (o.hp !== e.hp) $display("FAIL press_hp got %0d want %0d", o.hp, e.hp);
         else n_pass++;
         n_chk++;
         if (o.pv !== 1'b1 || o.lvl !== 1'b1)
            $display("FAIL press_pv_lvl got %b%b want 11", o.pv, o.lvl);
         else n_pass++;
      end
      btn_in = 1'b1;
      tick(10);
      n_chk++;
      if (btn_level !== 1'b0) $display("FAIL press_release got %b want 0", btn_level);
      else n_pass++;
   endtask

   task automatic test_bounce();
      for (int r = 0; r < 5; r++) begin
         btn_in = 1'b0;
         tick(DB - 1);
         btn_in = 1'b1;
         tick(1);
      end
      tick(20);
      n_chk++;
      if (obs_q.size() != 0) $display("FAIL bounce_press got %0d want 0", obs_q.size());
      else n_pass++;
      n_chk++;
      if (rate_idx !== exp_idx) $display("FAIL bounce_idx got %0d want %0d", rate_idx, exp_idx);
      else n_pass++;
      n_chk++;
      if (btn_level !== 1'b0) $display("FAIL bounce_level got %b want 0", btn_level);
      else n_pass++;
   endtask

   task automatic test_rate_cycle();
      exp_t e;
      obs_t o;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive_press();
         tick(10);
         btn_in = 1'b1;
         tick(10);
      end
      n_chk++;
      if (obs_q.size() != 4) $display("FAIL cycle_count got %0d want 4", obs_q.size());
      else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_chk++;
         if (o.cyc !== e.cyc) $display("FAIL cycle_time got %0d want %0d", o.cyc, e.cyc);
         else n_pass++;
         n_chk++;
         if (o.idx !== e.idx) $display("FAIL cycle_idx got %0d want %0d", o.idx, e.idx);
         else n_pass++;
         n_chk++;
         if (o.hp !== e.hp) $display("FAIL cycle_hp got %0d want %0d", o.hp, e.hp);
         else n_pass++;
         n_chk++;
         if (o.pv !== 1'b1) $display("FAIL cycle_pv got %b want 1", o.pv);
         else n_pass++;
      end
   endtask

   task automatic test_hold();
      exp_t e;
      obs_t o;
      int   rel;
      drive_press();
      tick(1000);
      rel = cyc;
      btn_in = 1'b1;
      tick(12);
      n_chk++;
      if (obs_q.size() != 1) $display("FAIL hold_count got %0d want 1", obs_q.size());
      else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_chk++;
         if (o.cyc !== e.cyc || o.idx !== e.idx)
            $display("FAIL hold_press got %0d/%0d want %0d/%0d", o.cyc, o.idx, e.cyc, e.idx);
         else n_pass++;
      end
      n_chk++;
      if (fall_cyc != rel + DB + 2)
         $display("FAIL hold_release got %0d want %0d", fall_cyc, rel + DB + 2);
      else n_pass++;
   endtask

   task automatic test_reset_abort();
      exp_t e;
      obs_t o;
      btn_in = 1'b0;
      tick(DB);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      exp_q.delete();
      obs_q.delete();
      exp_idx = 2'd0;
      n_chk++;
      if (rate_idx !== 2'd0 || half_period !== rate_tab[0])
         $display("FAIL abort_reset got %0d/%0d want 0/%0d", rate_idx, half_period, rate_tab[0]);
      else n_pass++;
      exp_idx = exp_idx + 2'd1;
      exp_q.push_back(exp_t'{cyc + DB + 2, exp_idx, rate_tab[exp_idx]});
      tick(12);
      n_chk++;
      if (obs_q.size() != 1) $display("FAIL abort_count got %0d want 1", obs_q.size());
      else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_chk++;
         if (o.cyc !== e.cyc) $display("FAIL abort_time got %0d want %0d", o.cyc, e.cyc);
         else n_pass++;
         n_chk++;
         if (o.idx !== e.idx || o.hp !== e.hp)
            $display("FAIL abort_rate got %0d/%0d want %0d/%0d", o.idx, o.hp, e.idx, e.hp);
         else n_pass++;
      end
      btn_in = 1'b1;
      tick(12);
   endtask

   task automatic test_pulse_width();
      n_chk++;
      if (dbl_press != 0) $display("FAIL press_width got %0d want 0", dbl_press);
      else n_pass++;
      n_chk++;
      if (dbl_pv != 0) $display("FAIL pv_width got %0d want 0", dbl_pv);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      btn_in = 1'b1;
      exp_idx = 2'd0;
      test_reset();
      test_press();
      test_bounce();
      test_rate_cycle();
      test_hold();
      test_reset_abort();
      test_pulse_width();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/btn_rate_ctrl.md
BTN_RATE_CTRL -- requirements
Module: btn_rate_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive cycles the synchronized button must hold a new level before that level is accepted; the legal range is 2 to 2^24-1.
REQ-002 Parameter BTN_ACTIVE_LOW, default 1; when it is 1, btn_in=0 means pressed.
REQ-003 Parameter RATE0, default 32'd10000000, is the half-period in cycles for rate index 0.
REQ-004 Parameter RATE1, default 32'd5000000, is the half-period in cycles for rate index 1.
REQ-005 Parameter RATE2, default 32'd2500000, is the half-period in cycles for rate index 2.
REQ-006 Parameter RATE3, default 32'd1250000, is the half-period in cycles for rate index 3.
REQ-007 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 Port btn_in, input, 1 bit: raw, asynchronous, bouncing push-button input.
REQ-010 Port btn_level, output, 1 bit, registered: debounced button state, 1 = pressed.
REQ-011 Port press, output, 1 bit, registered: one-cycle pulse when a press is accepted.
REQ-012 Port rate_idx, output, 2 bits, registered: currently selected rate index.
REQ-013 Port half_period, output, 32 bits, registered: blink half-period in cycles; this is the count the downstream blinker uses in place of its fixed 10000000 compare.
REQ-014 Port period_valid, output, 1 bit, registered: one-cycle pulse in the same cycle half_period takes a new value.

Function
REQ-015 btn_in shall pass through a two-flop synchronizer, then be polarity-normalized per BTN_ACTIVE_LOW to give s_pressed.
REQ-016 The debounce FSM shall have four states: RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
REQ-017 In RELEASED with s_pressed=1, the FSM shall go to CONFIRM_PRESS and load cnt=1.
REQ-018 In CONFIRM_PRESS with s_pressed=1, cnt shall increment; when cnt reaches DEBOUNCE_CYCLES-1, the FSM shall go to PRESSED.
REQ-019 In CONFIRM_PRESS with s_pressed=0, the FSM shall return to RELEASED and clear cnt, with no output change.
REQ-020 PRESSED and CONFIRM_RELEASE shall mirror REQ-017 to REQ-019, with s_pressed=0 as the candidate level.
REQ-021 The counter shall be 24 bits, shall never wrap, and shall hold 0 in the RELEASED and PRESSED states.
REQ-022 On each transition into PRESSED: btn_level<=1, press<=1 for exactly one cycle, and rate_idx<=rate_idx+1 modulo 4 (3 wraps to 0).
REQ-023 On each transition into RELEASED from CONFIRM_RELEASE: btn_level<=0; press, rate_idx and half_period are unchanged.
REQ-024 half_period shall equal RATE[rate_idx] and update in the same cycle as rate_idx; period_valid shall pulse high in that cycle.
REQ-025 Latency: with btn_in held steady, press shall assert exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new btn_in level.
REQ-026 Holding the button shall produce exactly one press pulse, regardless of hold duration.
REQ-027 A new press shall require a full debounced release first.
REQ-028 Any bounce shorter than DEBOUNCE_CYCLES consecutive cycles shall produce no output change.
REQ-029 press and period_valid shall never assert for more than one consecutive cycle.

Reset
REQ-030 While rst=1 at a clock edge, the following shall take these values: state=RELEASED, cnt=0, synchronizer flops=released level, btn_level=0, press=0, rate_idx=0, half_period=RATE0, period_valid=0.
REQ-031 rst asserted during CONFIRM_PRESS or CONFIRM_RELEASE shall abort confirmation with no press pulse; after reset, a still-held button shall be debounced afresh from RELEASED.
REQ-032 rst shall take priority over all other state updates in the same cycle.

Verification (benches use DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1)
REQ-033 Reset with btn_in=1 -> btn_level=0, press=0, rate_idx=0, half_period=10000000, period_valid=0.
REQ-034 Drive btn_in 1->0 and hold -> press and period_valid high for one cycle exactly 6 edges later, rate_idx=1, half_period=5000000, btn_level=1.
REQ-035 Bounce btn_in low 3 cycles, high 1 cycle, repeated 5 times, then high -> no press, rate_idx unchanged, btn_level=0.
REQ-036 Four clean press/release cycles from reset -> rate_idx goes 1,2,3,0 and half_period goes 5000000, 2500000, 1250000, 10000000; four press pulses total.
REQ-037 Hold the button pressed for 1000 cycles -> exactly one press pulse; btn_level returns to 0 exactly 6 edges after release.
REQ-038 Assert rst for 1 cycle at cnt=2 of CONFIRM_PRESS with the button still held -> no pulse at the aborted time, rate_idx=0, press occurs 6 edges after rst deasserts.
